// File: rtl/video_bin_pkg.sv
// Shared types and constants for the RGB565 binarize pipeline.
// Luma weights sum to 256 so Y is a plain byte select of the sum.
package video_bin_pkg;

  localparam int W_R = 77;
  localparam int W_G = 150;
  localparam int W_B = 29;

  localparam int Y_W        = 8;
  localparam int ACC_W      = 28;
  localparam int PIPE_DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    LOAD
  } ctl_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
  } side_t;

  function automatic rgb888_t expand565(
    input logic [15:0] p
  );
    rgb888_t c;
    c.r = {p[15:11], p[15:13]};
    c.g = {p[10:5], p[10:9]};
    c.b = {p[4:0], p[4:2]};
    return c;
  endfunction

  function automatic logic [7:0] sat_u8(
    input logic signed [10:0] v
  );
    if (v < 0) return 8'd0;
    if (v > 11'sd255) return 8'hFF;
    return v[7:0];
  endfunction

endpackage

// File: rtl/gray_threshold_binarize_mean_divider.sv
// mean_divider: 8-step restoring divide, quotient clamped to 255.
// Operands are latched on i_start; o_done marks the final step.
module mean_divider
  import video_bin_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [ACC_W-1:0] i_dividend,
  input  logic [CNT_W-1:0] i_divisor,
  output logic             o_done,
  output logic [Y_W-1:0]   o_quot
);

  localparam int RW =
    (ACC_W > CNT_W + 8) ? ACC_W : CNT_W + 8;

  logic [RW-1:0]  rem_d, rem_q;
  logic [RW-1:0]  den_d, den_q;
  logic [Y_W-1:0] quo_d, quo_q;
  logic [2:0]     it_d, it_q;
  logic           busy_d, busy_q;
  logic           ovf_d, ovf_q;

  always_comb begin
    rem_d  = rem_q;
    den_d  = den_q;
    quo_d  = quo_q;
    it_d   = it_q;
    busy_d = busy_q;
    ovf_d  = ovf_q;
    if (i_start) begin
      rem_d  = RW'(i_dividend);
      den_d  = RW'(i_divisor) << 7;
      quo_d  = '0;
      it_d   = '0;
      busy_d = 1'b1;
      // 8 quotient bits only hold if dividend < divisor*256
      ovf_d  = RW'(i_dividend) >=
               (RW'(i_divisor) << 8);
    end else if (busy_q) begin
      if (rem_q >= den_q) begin
        rem_d = rem_q - den_q;
        quo_d = {quo_q[6:0], 1'b1};
      end else begin
        quo_d = {quo_q[6:0], 1'b0};
      end
      den_d = den_q >> 1;
      it_d  = it_q + 3'd1;
      if (it_q == 3'd7) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      it_q   <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      quo_q  <= quo_d;
      it_q   <= it_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
    end
  end

  assign o_done = busy_q & (it_q == 3'd7);
  assign o_quot = ovf_q ? 8'hFF : quo_q;

endmodule

// File: rtl/gray_threshold_binarize.sv
// RGB565 -> luma -> 1-bit feature flag, 3-cycle pixel pipeline.
// Define ADAPTIVE_TH_EN to use each frame's mean luma as next threshold.
module gray_threshold_binarize
  import video_bin_pkg::*;
#(
  parameter logic [7:0] FIXED_TH  = 8'd128,
  parameter int         TH_OFFSET = 0,
  parameter int         CNT_W     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic [15:0] i_data,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_th,
  output logic [23:0] o_data,
  output logic [7:0]  o_mean
);

  side_t          s1_side_d, s1_side_q;
  side_t          s2_side_q, out_side_q;
  rgb888_t        s1_rgb_d, s1_rgb_q;
  logic [15:0]    luma_sum;
  logic [Y_W-1:0] s2_y_d, s2_y_q;
  logic [Y_W-1:0] th_use;
  logic           th_d, th_q;
  logic [23:0]    data_d, data_q;

  always_comb begin
    s1_rgb_d  = expand565(i_data);
    s1_side_d = '{hs: i_hs, vs: i_vs, de: i_de,
                  x: i_x, y: i_y};
  end

  always_comb begin
    luma_sum = 16'(W_R) * 16'(s1_rgb_q.r)
             + 16'(W_G) * 16'(s1_rgb_q.g)
             + 16'(W_B) * 16'(s1_rgb_q.b);
    s2_y_d   = Y_W'(luma_sum >> 8);
  end

  always_comb begin
    th_d   = s2_side_q.de & (s2_y_q < th_use);
    data_d = th_d ? 24'h000000 : 24'hFFFFFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_side_q  <= '0;
      s1_rgb_q   <= '0;
      s2_side_q  <= '0;
      s2_y_q     <= '0;
      out_side_q <= '0;
      th_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      s1_side_q  <= s1_side_d;
      s1_rgb_q   <= s1_rgb_d;
      s2_side_q  <= s1_side_q;
      s2_y_q     <= s2_y_d;
      out_side_q <= s2_side_q;
      th_q       <= th_d;
      data_q     <= data_d;
    end
  end

  assign o_hs   = out_side_q.hs;
  assign o_vs   = out_side_q.vs;
  assign o_de   = out_side_q.de;
  assign o_x    = out_side_q.x;
  assign o_y    = out_side_q.y;
  assign o_th   = th_q;
  assign o_data = data_q;

`ifdef ADAPTIVE_TH_EN

  logic              vs_prev_q;
  logic              vs_rise, vs_fall;
  logic [ACC_W-1:0]  acc_d, acc_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  ctl_state_e        state_d, state_q;
  logic [Y_W-1:0]    mean_d, mean_q;
  logic [Y_W-1:0]    th_pend_d, th_pend_q;
  logic [Y_W-1:0]    th_act_d, th_act_q;
  logic              pend_vld_d, pend_vld_q;
  logic              skip_d, skip_q;
  logic              div_start, div_done;
  logic [Y_W-1:0]    div_quot;
  logic signed [10:0] th_sum;

  assign vs_rise = s2_side_q.vs & ~vs_prev_q;
  assign vs_fall = ~s2_side_q.vs & vs_prev_q;

  // first pixel of a frame must already see the swapped threshold
  assign th_use = (vs_rise & pend_vld_q) ?
                  th_pend_q : th_act_q;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (vs_rise) begin
      acc_d = s2_side_q.de ? ACC_W'(s2_y_q) : '0;
      cnt_d = s2_side_q.de ? CNT_W'(1) : '0;
    end else if (s2_side_q.vs & s2_side_q.de) begin
      acc_d = acc_q + ACC_W'(s2_y_q);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  mean_divider #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_start   (div_start),
    .i_dividend(acc_q),
    .i_divisor (cnt_q),
    .o_done    (div_done),
    .o_quot    (div_quot)
  );

  always_comb begin
    th_sum = $signed({3'b000, div_quot})
           + 11'(TH_OFFSET);
  end

  always_comb begin
    state_d    = state_q;
    mean_d     = mean_q;
    th_pend_d  = th_pend_q;
    th_act_d   = th_act_q;
    pend_vld_d = pend_vld_q;
    skip_d     = skip_q;
    div_start  = 1'b0;
    if (vs_rise && pend_vld_q) begin
      th_act_d   = th_pend_q;
      pend_vld_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (vs_fall) begin
          state_d   = (cnt_q == '0) ? LOAD : DIV;
          skip_d    = (cnt_q == '0);
          div_start = (cnt_q != '0);
        end
      end
      DIV: begin
        if (div_done) state_d = LOAD;
      end
      LOAD: begin
        state_d = IDLE;
        // an empty frame leaves mean and threshold alone
        if (!skip_q) begin
          mean_d     = div_quot;
          th_pend_d  = sat_u8(th_sum);
          pend_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_q  <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      mean_q     <= '0;
      th_pend_q  <= FIXED_TH;
      th_act_q   <= FIXED_TH;
      pend_vld_q <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      vs_prev_q  <= s2_side_q.vs;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      mean_q     <= mean_d;
      th_pend_q  <= th_pend_d;
      th_act_q   <= th_act_d;
      pend_vld_q <= pend_vld_d;
      skip_q     <= skip_d;
    end
  end

  assign o_mean = mean_q;

`else

  assign th_use = FIXED_TH;
  assign o_mean = '0;

`endif

endmodule

// File: tb/tb_gray_threshold_binarize.sv
// Bench: fixed pixel vectors, random stream vs luma model, reset,
// and (with ADAPTIVE_TH_EN) hand-built frames for the mean threshold.
module tb_gray_threshold_binarize;

`ifdef ADAPTIVE_TH_EN
  localparam bit ADAPT = 1'b1;
`else
  localparam bit ADAPT = 1'b0;
`endif

  localparam int TH_A = 128;
  localparam int TH_B = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_hs, i_vs, i_de;
  logic [11:0] i_x, i_y;
  logic [15:0] i_data;

  logic        a_hs, a_vs, a_de, a_th;
  logic [11:0] a_x, a_y;
  logic [23:0] a_data;
  logic [7:0]  a_mean;

  logic        b_hs, b_vs, b_de, b_th;
  logic [11:0] b_x, b_y;
  logic [23:0] b_data;
  logic [7:0]  b_mean;

  always #5 clk = ~clk;

  gray_threshold_binarize dut (
    .clk(clk), .rst(rst),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_x(i_x), .i_y(i_y), .i_data(i_data),
    .o_hs(a_hs), .o_vs(a_vs), .o_de(a_de),
    .o_x(a_x), .o_y(a_y), .o_th(a_th),
    .o_data(a_data), .o_mean(a_mean)
  );

  gray_threshold_binarize #(
    .FIXED_TH(8'd100)
  ) dut100 (
    .clk(clk), .rst(rst),
    .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_x(i_x), .i_y(i_y), .i_data(i_data),
    .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de),
    .o_x(b_x), .o_y(b_y), .o_th(b_th),
    .o_data(b_data), .o_mean(b_mean)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] px;
    logic        de;
    logic        th;
    logic [23:0] data;
  } vec_t;

  typedef struct {
    logic        hs, vs, de;
    logic [11:0] x, y;
    logic        th, th100;
  } exp_t;

  vec_t tbl[9];
  exp_t q[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // luma straight from the bit-replication and weighting rules
  function automatic int luma(input logic [15:0] p);
    int r5, g6, b5, r8, g8, b8;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    r8 = r5 * 8 + r5 / 4;
    g8 = g6 * 4 + g6 / 16;
    b8 = b5 * 8 + b5 / 4;
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  task automatic cyc(input logic hs, input logic vs,
                     input logic de,
                     input logic [11:0] x,
                     input logic [11:0] y,
                     input logic [15:0] d);
    exp_t e, n;
    @(negedge clk);
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("pipe",
          {a_hs, a_vs, a_de, a_x, a_y, a_th, a_data},
          {e.hs, e.vs, e.de, e.x, e.y, e.th,
           e.th ? 24'h000000 : 24'hFFFFFF});
      chk("th100", {b_th, b_data, b_mean},
          {e.th100,
           e.th100 ? 24'h000000 : 24'hFFFFFF, 8'h00});
      chk("mean0", {56'd0, a_mean}, 64'd0);
    end
    i_hs = hs; i_vs = vs; i_de = de;
    i_x = x; i_y = y; i_data = d;
    n.hs = hs; n.vs = vs; n.de = de;
    n.x = x; n.y = y;
    n.th    = de && (luma(d) < TH_A);
    n.th100 = de && (luma(d) < TH_B);
    q.push_back(n);
  endtask

  task automatic px(input logic vs, input logic de,
                    input logic [15:0] d);
    @(negedge clk);
    i_hs = 1'b0; i_vs = vs; i_de = de;
    i_x = '0; i_y = '0; i_data = d;
  endtask

  initial begin
    logic        vsr;
    logic [15:0] pr;

    tbl[0] = '{16'hFFFF, 1'b1, 1'b0, 24'hFFFFFF};
    tbl[1] = '{16'h0000, 1'b1, 1'b1, 24'h000000};
    tbl[2] = '{16'h07E0, 1'b1, 1'b0, 24'hFFFFFF};
    tbl[3] = '{16'hF800, 1'b1, 1'b1, 24'h000000};
    tbl[4] = '{16'h0000, 1'b0, 1'b0, 24'hFFFFFF};
    tbl[5] = '{16'h83EF, 1'b1, 1'b1, 24'h000000};
    tbl[6] = '{16'h83F0, 1'b1, 1'b1, 24'h000000};
    tbl[7] = '{16'h001F, 1'b1, 1'b1, 24'h000000};
    tbl[8] = '{16'hFFDF, 1'b1, 1'b0, 24'hFFFFFF};

    rst = 1'b1;
    i_hs = 0; i_vs = 0; i_de = 0;
    i_x = '0; i_y = '0; i_data = '0;
    #12;
    chk("rst_th", {63'd0, a_th}, 64'd0);
    chk("rst_data", {40'd0, a_data}, 64'd0);
    chk("rst_mean", {56'd0, a_mean}, 64'd0);
    chk("rst_side", {a_hs, a_vs, a_de, a_x, a_y},
        64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[k]) begin
      @(negedge clk);
      i_vs = 1'b0; i_de = tbl[k].de;
      i_data = tbl[k].px;
      repeat (3) @(negedge clk);
      chk("tbl_th", {63'd0, a_th}, {63'd0, tbl[k].th});
      chk("tbl_data", {40'd0, a_data},
          {40'd0, tbl[k].data});
    end

    q.delete();
    for (int i = 0; i < 400; i++) begin
      vsr = ADAPT ? 1'b0 : (((i / 37) % 2) == 0);
      pr  = 16'($urandom);
      cyc(1'($urandom), vsr, 1'($urandom),
          12'($urandom), 12'($urandom), pr);
      if (i == 150) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_async",
            {a_hs, a_vs, a_de, a_x, a_y, a_th, a_data},
            64'd0);
        chk("rst_async_m", {56'd0, a_mean, b_th}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
      end
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0, '0, '0);
    q.delete();

`ifdef ADAPTIVE_TH_EN
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (2) px(1'b0, 1'b0, '0);

    for (int k = 0; k < 8; k++)
      px(1'b1, 1'b1, (k < 4) ? 16'hFFFF : 16'h0000);
    px(1'b0, 1'b0, '0);
    repeat (11) @(negedge clk);
    chk("mean_early", {56'd0, a_mean}, 64'd0);
    @(negedge clk);
    chk("mean_at10", {56'd0, a_mean}, 64'd127);
    repeat (3) px(1'b0, 1'b0, '0);

    px(1'b1, 1'b1, 16'h83EF);
    px(1'b1, 1'b1, 16'h83F0);
    px(1'b1, 1'b0, '0);
    @(negedge clk);
    chk("f2_y126", {63'd0, a_th}, 64'd1);
    @(negedge clk);
    chk("f2_y127", {63'd0, a_th}, 64'd0);
    repeat (15) px(1'b0, 1'b0, '0);
    chk("mean_f2", {56'd0, a_mean}, 64'd126);

    repeat (6) px(1'b1, 1'b0, '0);
    repeat (15) px(1'b0, 1'b0, '0);
    chk("mean_nodata", {56'd0, a_mean}, 64'd126);

    px(1'b1, 1'b1, 16'h83EF);
    px(1'b1, 1'b1, 16'h83EE);
    px(1'b1, 1'b0, '0);
    @(negedge clk);
    chk("f4_y126", {63'd0, a_th}, 64'd0);
    @(negedge clk);
    chk("f4_y125", {63'd0, a_th}, 64'd1);
    repeat (15) px(1'b0, 1'b0, '0);
    chk("mean_f4", {56'd0, a_mean}, 64'd125);

    for (int k = 0; k < 8; k++)
      px(1'b1, 1'b1, (k < 4) ? 16'hFFFF : 16'h0000);
    repeat (4) px(1'b0, 1'b0, '0);
    px(1'b1, 1'b1, 16'h83EF);
    px(1'b1, 1'b0, '0);
    px(1'b1, 1'b0, '0);
    @(negedge clk);
    chk("short_old_th", {63'd0, a_th}, 64'd0);
    repeat (12) px(1'b1, 1'b0, '0);
    chk("mean_f5", {56'd0, a_mean}, 64'd127);
    repeat (4) px(1'b0, 1'b0, '0);
    px(1'b1, 1'b1, 16'h83EF);
    px(1'b1, 1'b0, '0);
    px(1'b1, 1'b0, '0);
    @(negedge clk);
    chk("short_new_th", {63'd0, a_th}, 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
